alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  EX-stage execution unit; consumes the 4-bit ALU control code from the ALU control decoder.
//  AND/OR/ADD/SUB/SLL/SRL/SLT complete combinationally in one cycle.
//  MUL runs on an iterative multi-cycle shift-add datapath. While MUL runs, the unit raises
//  stall so hazard logic freezes PC, IF/ID and ID/EX; the EX inputs stay stable until done.
// PARAMETERS
//  MUL_CYCLES  4  iterations per MUL; legal 1,2,4,8,16,32; K = 32/MUL_CYCLES multiplier bits per iteration
// PORTS
//  clk        in   1   clock, rising edge
//  arst       in   1   asynchronous active-high reset
//  valid      in   1   EX stage holds a real instruction (0 = bubble)
//  flush      in   1   kill the current EX instruction (branch taken)
//  alu_ctrl   in   4   0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 6 SUB, 7 SLT, 8 MUL; others reserved
//  alu_in_0   in   32  operand A
//  alu_in_1   in   32  operand B (shift amount = alu_in_1[4:0])
//  alu_out    out  32  result
//  zero_flag  out  1   alu_out == 0
//  stall      out  1   1 = pipeline must hold; EX result not yet valid
// BEHAVIOUR
//  - FSM states: IDLE, BUSY, DONE. arst (async) -> IDLE; counter, accumulator and operand regs clear to 0.
//  - While arst is high: stall=0, alu_out=0, zero_flag=1.
//  - Non-MUL in IDLE: alu_out is combinational from the inputs, stall=0. ADD/SUB wrap mod 2^32.
//    SLL/SRL are logical shifts. SLT is a signed compare; result is 32'd1 or 32'd0.
//  - Reserved codes give alu_out=0.
//  - MUL start: IDLE, valid=1, flush=0, alu_ctrl=8 -> stall=1 combinationally in that cycle (t).
//    At the edge: mcand<=A, mplier<=B, acc<=0, cnt<=0, state goes to BUSY.
//  - BUSY: each cycle acc <= acc + mcand*mplier[K-1:0] (low 32 bits kept), mcand <<= K, mplier >>= K, cnt++.
//    stall=1 and alu_out=0. When cnt==MUL_CYCLES-1 the FSM goes to DONE.
//  - DONE: stall=0 and alu_out=acc (low 32 bits of A*B; same for signed and unsigned).
//    The pipeline advances at the end of this cycle. DONE -> IDLE unconditionally.
//    The still-present MUL inputs are never re-issued.
//  - Latency: MUL issued at cycle t; stall is high for cycles t..t+MUL_CYCLES; result is valid in
//    cycle t+MUL_CYCLES+1 with stall=0. MUL_CYCLES=4 gives exactly 5 stall cycles.
//  - flush has priority. flush=1 in IDLE stops a MUL from starting (stall=0). flush=1 in BUSY
//    forces IDLE at the next edge with stall=0 in that cycle. flush in DONE has no extra effect.
//  - valid=0 suppresses a MUL start: alu_out=0, stall=0.
//  - arst mid-BUSY: immediate IDLE, partial product discarded, stall drops asynchronously.
//  - Back-to-back MULs: the second starts from IDLE the cycle after DONE, with no overlap.
//  - zero_flag is always derived from the final alu_out value.
// CONFIGURATION
//  ALU_MUL_EARLY_OUT_EN defined: a MUL start with A==0 or B==0 (or B==1) goes IDLE -> DONE directly.
//    acc loads 0 (or A when B==1); stall is high only in start cycle t; result appears in cycle t+1.
//  ALU_MUL_EARLY_OUT_EN undefined: every MUL takes the full MUL_CYCLES iterations. No comparators
//    are synthesised.
// TESTING
//  1 ADD A=5,B=3, valid=1 -> alu_out=8, zero_flag=0, stall=0 in the same cycle; SUB 3-3 -> 0, zero_flag=1.
//  2 SLT A=32'hFFFFFFFF, B=1 -> alu_out=1; SRL A=32'h80000000, B=31 -> alu_out=1.
//  3 MUL A=7, B=6, MUL_CYCLES=4 -> stall=1 for 5 cycles, then stall=0 and alu_out=42 for one cycle.
//  4 MUL A=32'hFFFFFFFF, B=2 -> alu_out=32'hFFFFFFFE; MUL 32'h10000*32'h10000 -> alu_out=0, zero_flag=1.
//  5 arst pulse during BUSY cycle 2 -> stall=0 immediately; a following ADD 1+1 -> alu_out=2
//    with no leftover stall.
//  6 flush during BUSY -> IDLE next cycle, stall=0; with _EN defined, MUL A=0, B=9 -> stall 1 cycle,
//    alu_out=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/arith/shift/compare ops plus an iterative shift-add MUL that stalls the pipeline.
// Optional feature macro ALU_MUL_EARLY_OUT_EN: MUL with A==0, B==0 or B==1 skips the iterations.
module alu_exec_unit #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        valid,
    input  logic        flush,
    input  logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_in_0,
    input  logic [31:0] alu_in_1,
    output logic [31:0] alu_out,
    output logic        zero_flag,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_SLL = 4'd3,
        OP_SRL = 4'd4,
        OP_SUB = 4'd6,
        OP_SLT = 4'd7,
        OP_MUL = 4'd8
    } alu_op_t;

    localparam int          K        = 32 / MUL_CYCLES;
    localparam int          CNT_W    = 6;
    localparam logic [31:0] K_MASK   = 32'hFFFF_FFFF >> (32 - K);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      mcand_q, mcand_d;
    logic [31:0]      mplier_q, mplier_d;

    logic [31:0] comb_result;
    logic [31:0] partial;
    logic [31:0] result;
    logic        stall_c;

    always_comb begin
        comb_result = '0;
        case (alu_ctrl)
            OP_AND:  comb_result = alu_in_0 & alu_in_1;
            OP_OR:   comb_result = alu_in_0 | alu_in_1;
            OP_ADD:  comb_result = alu_in_0 + alu_in_1;
            OP_SUB:  comb_result = alu_in_0 - alu_in_1;
            OP_SLL:  comb_result = alu_in_0 << alu_in_1[4:0];
            OP_SRL:  comb_result = alu_in_0 >> alu_in_1[4:0];
            OP_SLT:  comb_result = {31'd0, $signed(alu_in_0) < $signed(alu_in_1)};
            default: comb_result = '0;
        endcase
    end

    // One radix-2^K step: only the low 32 bits of the running product matter.
    assign partial = mcand_q * (mplier_q & K_MASK);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        stall_c  = 1'b0;
        result   = '0;

        case (state_q)
            IDLE: begin
                if (alu_ctrl == OP_MUL) begin
                    if (valid && !flush) begin
                        stall_c  = 1'b1;
                        mcand_d  = alu_in_0;
                        mplier_d = alu_in_1;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = BUSY;
`ifdef ALU_MUL_EARLY_OUT_EN
                        if (alu_in_0 == '0 || alu_in_1 == '0) begin
                            state_d = DONE;
                        end else if (alu_in_1 == 32'd1) begin
                            acc_d   = alu_in_0;
                            state_d = DONE;
                        end
`endif
                    end
                end else begin
                    result = comb_result;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    stall_c  = 1'b1;
                    acc_d    = acc_q + partial;
                    mcand_d  = mcand_q << K;
                    mplier_d = mplier_q >> K;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = DONE;
                end
            end
            DONE: begin
                result  = acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset forces the outputs quiet even while the inputs still select an op.
        if (arst) begin
            stall_c = 1'b0;
            result  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign alu_out   = result;
    assign zero_flag = (result == '0);
    assign stall     = stall_c;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_alu_exec_unit;

    localparam int MUL_CYCLES = 4;

    localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_SLL = 4'd3,
                           C_SRL = 4'd4, C_RSV = 4'd5, C_SUB = 4'd6, C_SLT = 4'd7,
                           C_MUL = 4'd8;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [31:0] alu_in_0 = '0;
    logic [31:0] alu_in_1 = '0;
    logic [31:0] alu_out;
    logic        zero_flag;
    logic        stall;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        stall;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu_exec_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk       (clk),
        .arst      (arst),
        .valid     (valid),
        .flush     (flush),
        .alu_ctrl  (alu_ctrl),
        .alu_in_0  (alu_in_0),
        .alu_in_1  (alu_in_1),
        .alu_out   (alu_out),
        .zero_flag (zero_flag),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: the DUT presents a result every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".alu_out"}, alu_out, e.out);
            check({e.name, ".zero_flag"}, {31'd0, zero_flag}, {31'd0, (e.out == 32'd0)});
            check({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
        end
    end

    task automatic step(input logic r, input logic v, input logic f, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eo, input logic es, input string n);
        exp_t e;
        @(posedge clk);
        #1;
        arst     = r;
        valid    = v;
        flush    = f;
        alu_ctrl = c;
        alu_in_0 = a;
        alu_in_1 = b;
        e.name  = n;
        e.out   = eo;
        e.stall = es;
        sb_q.push_back(e);
    endtask

    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eo, input string n);
        step(1'b0, 1'b1, 1'b0, c, a, b, eo, 1'b0, n);
    endtask

    task automatic mul_seq(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eo, input string n);
        for (int i = 0; i <= MUL_CYCLES; i++)
            step(1'b0, 1'b1, 1'b0, C_MUL, a, b, 32'd0, 1'b1, n);
        step(1'b0, 1'b1, 1'b0, C_MUL, a, b, eo, 1'b0, {n, "_done"});
    endtask

    initial begin
        // Outputs held quiet during reset even with an ADD presented.
        step(1'b1, 1'b1, 1'b0, C_ADD, 32'd5, 32'd3, 32'd0, 1'b0, "reset_add");
        step(1'b1, 1'b1, 1'b0, C_MUL, 32'd7, 32'd6, 32'd0, 1'b0, "reset_mul");

        op(C_ADD, 32'd5, 32'd3, 32'd8, "add_5_3");
        op(C_SUB, 32'd3, 32'd3, 32'd0, "sub_3_3");
        op(C_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, "add_wrap");
        op(C_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_wrap");
        op(C_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, "and");
        op(C_OR,  32'hFF00_0000, 32'h0000_00F0, 32'hFF00_00F0, "or");
        op(C_SLL, 32'd1, 32'h0000_0024, 32'd16, "sll_amt_masked");
        op(C_SRL, 32'h8000_0000, 32'd31, 32'd1, "srl_31");
        op(C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt_neg_pos");
        op(C_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, "slt_pos_neg");
        op(C_RSV, 32'd9, 32'd9, 32'd0, "reserved");
        step(1'b0, 1'b0, 1'b0, C_MUL, 32'd7, 32'd6, 32'd0, 1'b0, "mul_bubble");
        step(1'b0, 1'b1, 1'b1, C_MUL, 32'd7, 32'd6, 32'd0, 1'b0, "mul_flush_idle");

        mul_seq(32'd7, 32'd6, 32'd42, "mul_7_6");
        op(C_ADD, 32'd2, 32'd2, 32'd4, "add_after_mul");
        mul_seq(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul_ff_2");
        mul_seq(32'h0001_0000, 32'h0001_0000, 32'd0, "mul_overflow");
        mul_seq(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, "mul_ff_ff");
        mul_seq(32'd3, 32'd5, 32'd15, "mul_b2b");

        // flush during BUSY
        step(1'b0, 1'b1, 1'b0, C_MUL, 32'd7, 32'd6, 32'd0, 1'b1, "flush_start");
        step(1'b0, 1'b1, 1'b0, C_MUL, 32'd7, 32'd6, 32'd0, 1'b1, "flush_busy1");
        step(1'b0, 1'b1, 1'b1, C_MUL, 32'd7, 32'd6, 32'd0, 1'b0, "flush_busy2");
        op(C_ADD, 32'd4, 32'd5, 32'd9, "add_after_flush");

        // async reset during BUSY cycle 2
        step(1'b0, 1'b1, 1'b0, C_MUL, 32'd7, 32'd6, 32'd0, 1'b1, "arst_start");
        step(1'b0, 1'b1, 1'b0, C_MUL, 32'd7, 32'd6, 32'd0, 1'b1, "arst_busy1");
        step(1'b1, 1'b1, 1'b0, C_MUL, 32'd7, 32'd6, 32'd0, 1'b0, "arst_busy2");
        op(C_ADD, 32'd1, 32'd1, 32'd2, "add_after_arst");

`ifdef ALU_MUL_EARLY_OUT_EN
        step(1'b0, 1'b1, 1'b0, C_MUL, 32'd0, 32'd9, 32'd0, 1'b1, "early_zero_start");
        step(1'b0, 1'b1, 1'b0, C_MUL, 32'd0, 32'd9, 32'd0, 1'b0, "early_zero_done");
        step(1'b0, 1'b1, 1'b0, C_MUL, 32'd5, 32'd1, 32'd0, 1'b1, "early_one_start");
        step(1'b0, 1'b1, 1'b0, C_MUL, 32'd5, 32'd1, 32'd5, 1'b0, "early_one_done");
`else
        mul_seq(32'd0, 32'd9, 32'd0, "mul_0_9");
        mul_seq(32'd5, 32'd1, 32'd5, "mul_5_1");
`endif
        op(C_OR, 32'd0, 32'd0, 32'd0, "or_zero");

        // Let the monitor drain the last expectation.
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
